// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART TX arbiter and its helpers.
package uart_arb_pkg;

  localparam int MAX_NREQ = 8;
  localparam int BYTE_W   = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_ABORT = 2'd2
  } arb_state_e;

  // Idle counter width: must hold the timeout value itself; one bit minimum
  // so a disabled timeout still yields a legal vector.
  function automatic int cnt_width(input int unsigned timeout);
    return (timeout == 0) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin pick: first asserted request strictly after ptr,
// wrapping modulo N, with ptr itself considered last.
module rr_picker #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          hit,
  output logic [IW-1:0] idx
);

  // Walk candidates farthest-first so the nearest one after ptr wins.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int k = N; k >= 1; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        hit = 1'b1;
        idx = IW'((int'(ptr) + k) % N);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing the UART TX FIFO write port
// between NREQ requesters, with a per-grant mid-packet inactivity timeout.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | no grant held; pick next requester, accept no bytes
// ST_SEND  | grant held; pass granted bytes to the FIFO until last byte
// ST_ABORT | one-cycle abort pulse after a timeout, then back to idle
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int          NREQ    = 4,
  parameter int unsigned TIMEOUT = 255,
  localparam int         IW      = $clog2(NREQ)
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [BYTE_W*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]        req_last,
  output logic [NREQ-1:0]        req_ready,
  output logic [BYTE_W-1:0]      uart_data,
  output logic                   uart_write,
  input  logic                   uart_full,
  output logic                   busy,
  output logic [IW-1:0]          grant_id,
  output logic                   abort,
  output logic [IW-1:0]          abort_id
);

  localparam int            CW      = cnt_width(TIMEOUT);
  localparam logic [CW-1:0] TO_VAL  = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [IW-1:0] PTR_RST = IW'(NREQ - 1);

  arb_state_e    state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [IW-1:0] abort_id_q, abort_id_d;
  logic          abort_q, abort_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          pick_hit;
  logic [IW-1:0] pick_idx;
  logic          gnt_valid;
  logic          gnt_last;
  logic          timeout_fire;
  logic          send_open;
  logic          accept;

  rr_picker #(
    .N  (NREQ),
    .IW (IW)
  ) u_picker (
    .req (req_valid),
    .ptr (ptr_q),
    .hit (pick_hit),
    .idx (pick_idx)
  );

  // Granted requester's byte straight to the FIFO; a firing timeout closes
  // the port in the same cycle so a late valid cannot sneak a byte through.
  always_comb begin
    gnt_valid    = req_valid[grant_q];
    gnt_last     = req_last[grant_q];
    uart_data    = req_data[grant_q*BYTE_W +: BYTE_W];
    timeout_fire = (state_q == ST_SEND) && (TIMEOUT != 0) && (cnt_q == TO_VAL);
    send_open    = RST_N && (state_q == ST_SEND) && !timeout_fire && !uart_full;
    accept       = send_open && gnt_valid;
    uart_write   = accept;
    req_ready    = '0;
    if (send_open) begin
      req_ready[grant_q] = 1'b1;
    end
  end

  // Next-state logic: arbitration, packet tracking and idle timeout.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_d    = grant_q;
    abort_id_d = abort_id_q;
    abort_d    = 1'b0;
    cnt_d      = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_hit) begin
          grant_d = pick_idx;
          ptr_d   = pick_idx;
          cnt_d   = '0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (timeout_fire) begin
          state_d    = ST_ABORT;
          abort_d    = 1'b1;
          abort_id_d = grant_q;
          cnt_d      = '0;
        end else if (accept) begin
          cnt_d = '0;
          if (gnt_last) begin
            state_d = ST_IDLE;
          end
        end else if (!gnt_valid) begin
          // Only requester silence counts; a full FIFO holds the count.
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ST_ABORT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered-output flops with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q    <= ST_IDLE;
      ptr_q      <= PTR_RST;
      grant_q    <= '0;
      abort_id_q <= '0;
      abort_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      abort_id_q <= abort_id_d;
      abort_q    <= abort_d;
      cnt_q      <= cnt_d;
    end
  end

  assign busy     = (state_q == ST_SEND);
  assign grant_id = grant_q;
  assign abort    = abort_q;
  assign abort_id = abort_id_q;

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single transmit path of the UART wrapper (byte-wide write port into the TX FIFO) between `NREQ` independent requesters. Arbitration is round-robin at packet granularity: the grant is held from a packet's first byte until its `last` byte is accepted. A per-grant inactivity timeout prevents a stalled requester from locking out the rest. It sits between bus-side producers (CPU port, debug/monitor, DMA) and the wrapper's `dataIn`/`write`/full interface.

## Interface
- `NREQ`, 4, number of requesters (2..8)
- `TIMEOUT`, 255, cycles a granted requester may idle mid-packet before abort; 0 disables the timeout
- `CLK` in 1 system clock, all logic on rising edge
- `RST_N` in 1 synchronous, active-low reset
- `req_valid` in NREQ per-requester byte valid
- `req_data` in 8*NREQ per-requester byte; requester i on bits [8i+7:8i]
- `req_last` in NREQ marks final byte of requester's packet
- `req_ready` out NREQ byte accepted this cycle when valid & ready
- `uart_data` out 8 byte to wrapper `dataIn`
- `uart_write` out 1 write strobe to wrapper `write`
- `uart_full` in 1 TX FIFO full flag from wrapper (status bit 8)
- `busy` out 1 a packet grant is held
- `grant_id` out clog2(NREQ) index of current/last granted requester
- `abort` out 1 one-cycle pulse: grant revoked by timeout
- `abort_id` out clog2(NREQ) requester that was aborted, held until next abort

## Operation
- FSM states: IDLE, SEND, ABORT.
- IDLE: round-robin pick among asserted `req_valid`, searching from `ptr+1` modulo NREQ upward. On any hit: register `grant_id`=winner, `ptr`=winner, clear timeout counter, go SEND. No bytes accepted in IDLE.
- SEND: `req_ready[grant_id]` = !`uart_full`; all other ready bits 0. `uart_data` = `req_data[grant_id]`, `uart_write` = `req_valid[grant_id]` & !`uart_full` (combinational pass-through, no extra buffering).
  - Beat accepted with `req_last`=1 -> IDLE.
  - Beat accepted with `req_last`=0 -> stay, counter cleared.
  - `req_valid[grant_id]`=0 -> counter +1; counter reaching `TIMEOUT` (TIMEOUT≠0) -> ABORT.
  - `uart_full`=1 with valid high -> stall, counter held (backpressure is not requester idleness).
- ABORT: one cycle; `abort`=1, `abort_id`=`grant_id`; -> IDLE. Remaining bytes of that packet arrive later as a new packet.
- `busy` = state is SEND.
- Timeout counter width clog2(TIMEOUT+1), saturates, never wraps.
- Requester rules: once `req_valid` is high it holds data/last stable until accepted.

## Timing
- Reset (RST_N low at an edge): state IDLE, `ptr`=NREQ-1 (requester 0 wins first), `grant_id`=0, `abort_id`=0, `abort`=0, counter 0. While RST_N low, `req_ready`=0 and `uart_write`=0 combinationally, including reset asserted mid-packet; no partial byte written.
- Arbitration latency: request seen in IDLE at cycle n -> grant in SEND at n+1 -> first byte written at n+1 if FIFO not full.
- Throughput: 1 byte/cycle within a packet; one idle cycle between packets (IDLE bubble).
- Simultaneous `req_last` and `uart_full`: not accepted, grant held.
- Valid rising in the same cycle timeout fires: abort wins; byte not accepted.
- Timeout: with TIMEOUT=T, `abort` asserts T+1 cycles after the first idle SEND cycle.

## Structure
- Package `uart_arb_pkg`: FSM state encoding (IDLE/SEND/ABORT), max NREQ constant, byte width constant.
- Sub-module `rr_picker`: combinational round-robin priority pick (inputs request vector and pointer; outputs hit and index); reusable for other shared wrapper ports.
- Everything else (FSM, counter, mux) in `uart_tx_arbiter`.

## Test plan
- Single packet: req0 sends 0x41,0x42,0x43(last), uart_full=0 -> uart_write on 3 consecutive cycles after one grant cycle, data 41/42/43, busy drops after 0x43.
- Fairness: req0 and req2 both hold 2-byte packets continuously -> grants alternate 0,2,0,2; no byte interleaving within a packet.
- Backpressure: uart_full high 10 cycles mid-packet -> no writes, req_ready=0, no abort with TIMEOUT=4, packet completes after full drops.
- Timeout: TIMEOUT=4, req1 drops valid after first byte -> abort pulse with abort_id=1, then req3 pending is granted.
- Reset mid-packet: RST_N low during byte 2 of 4 -> uart_write=0 that cycle, state IDLE, next grant goes to requester 0 first.
- TIMEOUT=0: requester idles 1000 cycles mid-packet -> no abort, grant held, resumes cleanly.
